tx_ipv4: RTL and testbench

IPv4 transmit framer: the transmit-side counterpart of the IPv4 receive parser. On a start request it latches destination IP, protocol and payload length, computes the header checksum, then emits a 20-byte IPv4 header (no options) followed by the payload bytes. Payload is pulled from the upper layer (UDP tx) through a read-request handshake. Output is one byte per cycle toward the Ethernet tx framer, with no backpressure.

---
 rtl/tx_ipv4.sv | 222 ++++++++++++++++++++++
 tb/tb_tx_ipv4.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ipv4.sv
// tx_ipv4: IPv4 transmit framer. Latches a start request, sums the header, then streams a 20-byte header plus payload.
// Latency: tx_start edge to first header byte is 11 cycles; the datagram then streams at one byte per cycle.
// Backpressure: none downstream; payload is pulled one cycle ahead through tx_data_req (FWFT source).
module tx_ipv4 #(
  parameter int         OCT = 8,
  parameter logic [7:0] TTL = 8'h40,
  parameter logic       DF  = 1'b1
) (
  input  logic           TX_CLK,
  input  logic           rst,
  input  logic [31:0]    ip_addr,
  input  logic [31:0]    tx_dst_ip,
  input  logic [7:0]     tx_protocol,
  input  logic [15:0]    tx_data_len,
  input  logic           tx_start,
  output logic           tx_busy,
  output logic           tx_err,
  output logic           tx_data_req,
  input  logic [OCT-1:0] tx_data,
  output logic           tx_payload_ipv4,
  output logic [OCT-1:0] tx_payload
);

  // Largest payload that still fits a 16-bit total_len after the 20-byte header.
  localparam logic [15:0] MAX_LEN   = 16'd65515;
  localparam logic [15:0] HDR_BYTES = 16'd20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSUM,
    S_FOLD,
    S_HDR,
    S_DATA
  } state_t;

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           req_q, req_d;
  logic           vld_q, vld_d;
  logic [OCT-1:0] pay_q, pay_d;
  logic [15:0]    id_q, id_d;
  logic [31:0]    src_q, src_d;
  logic [31:0]    dst_q, dst_d;
  logic [7:0]     proto_q, proto_d;
  logic [15:0]    len_q, len_d;
  logic [31:0]    acc_q, acc_d;
  logic [15:0]    csum_q, csum_d;
  // Shared step counter: checksum word index, header byte index, then payload byte count.
  logic [15:0]    cnt_q, cnt_d;

  logic [15:0]    total_len;
  logic [3:0]     word_idx;
  logic [15:0]    word;
  logic [16:0]    fold1;
  logic [15:0]    fold2;

  assign total_len = HDR_BYTES + len_q;

  // Header word index: checksum pass skips the checksum slot (word 5), header pass walks bytes pairwise.
  always_comb begin
    word_idx = cnt_q[4:1];
    if (state_q == S_CSUM) begin
      if (cnt_q[3:0] < 4'd5) begin
        word_idx = cnt_q[3:0];
      end else begin
        word_idx = cnt_q[3:0] + 4'd1;
      end
    end
  end

  // Header word table in wire order, one 16-bit big-endian word per slot.
  always_comb begin
    word = 16'h0000;
    case (word_idx)
      4'd0:    word = 16'h4500;
      4'd1:    word = total_len;
      4'd2:    word = id_q;
      4'd3:    word = {1'b0, DF, 14'h0000};
      4'd4:    word = {TTL, proto_q};
      4'd5:    word = csum_q;
      4'd6:    word = src_q[31:16];
      4'd7:    word = src_q[15:0];
      4'd8:    word = dst_q[31:16];
      4'd9:    word = dst_q[15:0];
      default: word = 16'h0000;
    endcase
  end

  // Two-stage end-around carry fold of the 32-bit accumulator.
  always_comb begin
    fold1 = {1'b0, acc_q[15:0]} + {1'b0, acc_q[31:16]};
    fold2 = fold1[15:0] + {15'h0000, fold1[16]};
  end

  // Next-state logic for the framer sequence and all registered outputs.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    req_d   = req_q;
    vld_d   = vld_q;
    pay_d   = pay_q;
    id_d    = id_q;
    src_d   = src_q;
    dst_d   = dst_q;
    proto_d = proto_q;
    len_d   = len_q;
    acc_d   = acc_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          if (tx_data_len > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            src_d   = ip_addr;
            dst_d   = tx_dst_ip;
            proto_d = tx_protocol;
            len_d   = tx_data_len;
            busy_d  = 1'b1;
            acc_d   = 32'h0000_0000;
            cnt_d   = 16'h0000;
            state_d = S_CSUM;
          end
        end
      end

      S_CSUM: begin
        acc_d = acc_q + {16'h0000, word};
        cnt_d = cnt_q + 16'd1;
        if (cnt_q[3:0] == 4'd8) begin
          cnt_d   = 16'h0000;
          state_d = S_FOLD;
        end
      end

      S_FOLD: begin
        csum_d  = ~fold2;
        cnt_d   = 16'h0000;
        state_d = S_HDR;
      end

      S_HDR: begin
        vld_d = 1'b1;
        pay_d = cnt_q[0] ? word[OCT-1:0] : word[2*OCT-1:OCT];
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HDR_BYTES - 16'd1) begin
          // Request the first payload byte alongside the last header byte so data follows gap-free.
          req_d   = (len_q != 16'h0000);
          cnt_d   = 16'h0000;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (cnt_q == len_q) begin
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          req_d   = 1'b0;
          id_d    = id_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          pay_d = tx_data;
          cnt_d = cnt_q + 16'd1;
          req_d = (({1'b0, cnt_q} + 17'd1) < {1'b0, len_q});
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge TX_CLK or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      pay_q   <= '0;
      id_q    <= 16'h0000;
      src_q   <= 32'h0000_0000;
      dst_q   <= 32'h0000_0000;
      proto_q <= 8'h00;
      len_q   <= 16'h0000;
      acc_q   <= 32'h0000_0000;
      csum_q  <= 16'h0000;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      pay_q   <= pay_d;
      id_q    <= id_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      proto_q <= proto_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_busy         = busy_q;
  assign tx_err          = err_q;
  assign tx_data_req     = req_q;
  assign tx_payload_ipv4 = vld_q;
  assign tx_payload      = pay_q;

endmodule

// File: tb/tb_tx_ipv4.sv
// Testbench for tx_ipv4: expected datagram bytes are queued at start time and popped as bytes appear.
`timescale 1ns/1ps
module tb_tx_ipv4;

  localparam logic [31:0] MY_IP  = 32'hC0A8010A;
  localparam logic [31:0] DST_IP = 32'hC0A80101;

  logic        TX_CLK = 1'b0;
  logic        rst;
  logic [31:0] ip_addr;
  logic [31:0] tx_dst_ip;
  logic [7:0]  tx_protocol;
  logic [15:0] tx_data_len;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_err;
  logic        tx_data_req;
  logic [7:0]  tx_data;
  logic        tx_payload_ipv4;
  logic [7:0]  tx_payload;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_id;

  tx_ipv4 dut (
    .TX_CLK          (TX_CLK),
    .rst             (rst),
    .ip_addr         (ip_addr),
    .tx_dst_ip       (tx_dst_ip),
    .tx_protocol     (tx_protocol),
    .tx_data_len     (tx_data_len),
    .tx_start        (tx_start),
    .tx_busy         (tx_busy),
    .tx_err          (tx_err),
    .tx_data_req     (tx_data_req),
    .tx_data         (tx_data),
    .tx_payload_ipv4 (tx_payload_ipv4),
    .tx_payload      (tx_payload)
  );

  always #5 TX_CLK = ~TX_CLK;

  function automatic logic [7:0] pay_byte(input int i);
    logic [31:0] t;
    t = i * 37 + 90;
    return t[7:0];
  endfunction

  // Reference header: ones-complement sum with end-around carry after every word.
  task automatic push_model_hdr(input logic [31:0] dst, input logic [7:0] proto,
                                input logic [15:0] len, input logic [15:0] id);
    logic [15:0] w[10];
    logic [31:0] s;
    w[0] = 16'h4500;
    w[1] = 16'd20 + len;
    w[2] = id;
    w[3] = 16'h4000;
    w[4] = {8'h40, proto};
    w[5] = 16'h0000;
    w[6] = MY_IP[31:16];
    w[7] = MY_IP[15:0];
    w[8] = dst[31:16];
    w[9] = dst[15:0];
    s = 32'h0;
    for (int i = 0; i < 10; i++) begin
      s = s + {16'h0, w[i]};
      s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    end
    w[5] = ~s[15:0];
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(w[i][15:8]);
      exp_q.push_back(w[i][7:0]);
    end
  endtask

  // Drives one start request and scoreboards the resulting frame; abort_at >= 0 resets while that payload byte is out.
  task automatic run_frame(input string name, input logic [31:0] dst, input logic [7:0] proto,
                           input logic [15:0] len, input bit use_model, input bit poke,
                           input int abort_at);
    int first_n, last_n, hdr19_n, req_first_n, vcnt, rcnt, err_seen, budget, npush;
    bit done;
    logic [7:0] e;
    first_n = -1; last_n = -1; hdr19_n = -1; req_first_n = -1;
    vcnt = 0; rcnt = 0; err_seen = 0; done = 0;
    budget = 60 + int'(len);
    if (use_model) push_model_hdr(dst, proto, len, exp_id);
    npush = (abort_at >= 0 && abort_at + 1 < int'(len)) ? abort_at + 1 : int'(len);
    for (int i = 0; i < npush; i++) exp_q.push_back(pay_byte(i));

    tx_dst_ip   = dst;
    tx_protocol = proto;
    tx_data_len = len;
    tx_start    = 1'b1;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge TX_CLK);
      tx_start = poke && (n == 5);
      if (poke && n == 5) tx_data_len = 16'hFFFF;
      if (tx_err) err_seen++;
      if (tx_payload_ipv4) begin
        if (first_n < 0) first_n = n;
        last_n = n;
        vcnt++;
        if (vcnt == 20) hdr19_n = n;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra byte %0d: got %02h, none expected", name, vcnt - 1, tx_payload);
        end else begin
          e = exp_q.pop_front();
          if (tx_payload !== e) begin
            errors++;
            $display("FAIL %s byte %0d: got %02h expected %02h", name, vcnt - 1, tx_payload, e);
          end
        end
      end
      tx_data = pay_byte(rcnt);
      if (tx_data_req) begin
        if (req_first_n < 0) req_first_n = n;
        rcnt++;
      end
      if (abort_at >= 0 && vcnt == 21 + abort_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if ({tx_payload_ipv4, tx_data_req, tx_busy, tx_err} !== 4'b0000 || tx_payload !== 8'h00) begin
          errors++;
          $display("FAIL %s async_reset: vld/req/busy/err=%b payload=%02h expected 0000/00", name,
                   {tx_payload_ipv4, tx_data_req, tx_busy, tx_err}, tx_payload);
        end
        @(negedge TX_CLK);
        rst = 1'b0;
        exp_q.delete();
        exp_id = 16'h0000;
        return;
      end
      if (vcnt > 0 && !tx_payload_ipv4) begin
        done = 1;
        checks++;
        if (tx_busy !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_end: got %b expected 0", name, tx_busy);
        end
      end
    end

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: frame end not seen within %0d cycles", name, budget);
    end
    checks++;
    if (first_n !== 11) begin
      errors++;
      $display("FAIL %s latency: got %0d expected 11", name, first_n);
    end
    checks++;
    if (vcnt !== 20 + int'(len) || last_n - first_n + 1 !== vcnt) begin
      errors++;
      $display("FAIL %s valid_run: got %0d cycles span %0d expected %0d contiguous", name, vcnt,
               last_n - first_n + 1, 20 + int'(len));
    end
    checks++;
    if (rcnt !== int'(len)) begin
      errors++;
      $display("FAIL %s req_count: got %0d expected %0d", name, rcnt, len);
    end
    if (len != 0) begin
      checks++;
      if (req_first_n !== hdr19_n) begin
        errors++;
        $display("FAIL %s req_align: got cycle %0d expected %0d", name, req_first_n, hdr19_n);
      end
    end
    checks++;
    if (err_seen !== 0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s leftovers: err pulses %0d, unmatched bytes %0d, expected 0/0", name, err_seen,
               exp_q.size());
    end
    exp_q.delete();
    exp_id = exp_id + 16'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ip_addr = MY_IP;
    tx_dst_ip = 32'h0; tx_protocol = 8'h0; tx_data_len = 16'h0;
    tx_start = 1'b0; tx_data = 8'h0;
    exp_id = 16'h0000;
    repeat (3) @(negedge TX_CLK);
    checks++;
    if ({tx_busy, tx_err, tx_data_req, tx_payload_ipv4} !== 4'b0000 || tx_payload !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: busy/err/req/vld=%b payload=%02h expected 0000/00",
               {tx_busy, tx_err, tx_data_req, tx_payload_ipv4}, tx_payload);
    end
    rst = 1'b0;
    @(negedge TX_CLK);
  endtask

  task automatic test_basic();
    logic [7:0] hdr[20];
    hdr = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
            8'hB7, 8'h75, 8'hC0, 8'hA8, 8'h01, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'h01};
    for (int i = 0; i < 20; i++) exp_q.push_back(hdr[i]);
    run_frame("basic", DST_IP, 8'h11, 16'd8, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b", DST_IP, 8'h11, 16'd8, 1'b1, 1'b1, -1);
    run_frame("b2b_3", 32'h0A000001, 8'h06, 16'd3, 1'b1, 1'b0, -1);
  endtask

  task automatic test_zero_payload();
    run_frame("zero_len", DST_IP, 8'h11, 16'd0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_frame();
    run_frame("mid_reset", DST_IP, 8'h11, 16'd8, 1'b1, 1'b0, 3);
    run_frame("after_reset", DST_IP, 8'h11, 16'd8, 1'b1, 1'b0, -1);
  endtask

  task automatic test_len_limit();
    int errs, err_n, busy_seen, vld_seen;
    errs = 0; err_n = -1; busy_seen = 0; vld_seen = 0;
    tx_dst_ip = DST_IP; tx_protocol = 8'h11; tx_data_len = 16'd65516; tx_start = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge TX_CLK);
      tx_start = 1'b0;
      if (tx_err) begin errs++; if (err_n < 0) err_n = n; end
      if (tx_busy) busy_seen++;
      if (tx_payload_ipv4) vld_seen++;
    end
    checks++;
    if (errs !== 1 || err_n !== 0) begin
      errors++;
      $display("FAIL len_reject_err: got %0d pulses at cycle %0d expected 1 at 0", errs, err_n);
    end
    checks++;
    if (busy_seen !== 0 || vld_seen !== 0) begin
      errors++;
      $display("FAIL len_reject_idle: busy cycles %0d valid cycles %0d expected 0/0", busy_seen, vld_seen);
    end
    run_frame("len_max", DST_IP, 8'h11, 16'd65515, 1'b1, 1'b0, 3);
  endtask

  task automatic test_id_wrap();
    force dut.id_q = 16'hFFFF;
    @(posedge TX_CLK);
    #1 release dut.id_q;
    @(negedge TX_CLK);
    exp_id = 16'hFFFF;
    run_frame("id_ffff", DST_IP, 8'h11, 16'd4, 1'b1, 1'b0, -1);
    run_frame("id_0000", DST_IP, 8'h11, 16'd4, 1'b1, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_payload();
    test_reset_mid_frame();
    test_len_limit();
    test_id_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
